multicycle_control_fsm: RTL and testbench

- Main control FSM for the multicycle variant of the RV32I core.
- Sequences one shared ALU, one shared memory port and the register file across 3-5 cycles per instruction.
- Drives the 2-bit ALU-op class into the existing combinational ALU decoder: 00 add, 01 subtract/compare, 10 funct-decoded.
- Adds memory wait-state handling, a wait timeout trap and a retired-instruction counter.

---
 rtl/multicycle_control_fsm_pkg.sv | 61 ++++++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 33 +++
 rtl/multicycle_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control FSM.
// Contents: state encodings, opcode constants, datapath mux-select codes,
// trap-cause codes and an opcode-to-next-state helper used in DECODE.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic CAUSE_ILLEGAL = 1'b0;
   localparam logic CAUSE_TIMEOUT = 1'b1;

   // Dispatch target out of DECODE; unknown opcodes land in TRAP.
   function automatic state_t decode_next(input logic [6:0] op);
      state_t s;
      case (op)
         OP_LOAD, OP_STORE: s = S_MEMADR;
         OP_RTYPE:          s = S_EXECR;
         OP_ITYPE:          s = S_EXECI;
         OP_BEQ:            s = S_BEQ;
         OP_JAL:            s = S_JAL;
         default:           s = S_TRAP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// mem_wait_timer: counts consecutive cycles a memory access has waited.
// Ports: clk, rst_n (async active-low), clear (zero the count),
//        waiting (access stalled this cycle), expired (this stalled cycle is
//        the WAIT_LIMIT-th consecutive one; the access must be abandoned).
module mem_wait_timer #(
   parameter int WAIT_LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   output logic expired
);

   // Count holds the number of stalled cycles already completed, so the
   // current stall is the last permitted one when count equals LIMIT-1.
   localparam logic [7:0] LAST = 8'(WAIT_LIMIT - 1);

   logic [7:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (waiting) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   assign expired = waiting && (count_reg == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM of the multicycle RV32I core.
// Inputs : clk, rst_n (async active-low), op (IR opcode), zero (ALU flag),
//          mem_ready (memory completes current access this cycle).
// Outputs: datapath enables/selects (pc_write, adr_src, mem_write, ir_write,
//          result_src, alu_src_a, alu_src_b, alu_op, reg_write), retire pulse,
//          ret_count, sticky trap with trap_cause (0 illegal op, 1 timeout).
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int RET_W      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             adr_src,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       result_src,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             retire,
   output logic [RET_W-1:0] ret_count,
   output logic             trap,
   output logic             trap_cause
);

   state_t state_reg, state_next;
   logic [RET_W-1:0] ret_count_reg;
   logic trap_reg, trap_cause_reg, cause_next;
   logic pc_write_c, mem_write_c, ir_write_c, reg_write_c, retire_c;
   logic wait_state, timer_clear, timer_waiting, timer_expired;

   // Only FETCH, MEMREAD and MEMWRITE talk to memory. Holding the counter at
   // zero everywhere else makes "clear on entry" automatic.
   assign wait_state    = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                          (state_reg == S_MEMWRITE);
   assign timer_clear   = !wait_state || mem_ready;
   assign timer_waiting = wait_state && !mem_ready;

   mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .waiting (timer_waiting),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_FETCH;
         ret_count_reg  <= '0;
         trap_reg       <= 1'b0;
         trap_cause_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (retire_c) begin
            ret_count_reg <= ret_count_reg + RET_W'(1);
         end
         // Cause is latched only on the way in, so it stays stable in TRAP.
         if (state_next == S_TRAP && state_reg != S_TRAP) begin
            trap_reg       <= 1'b1;
            trap_cause_reg <= cause_next;
         end
      end
   end

   always_comb begin
      state_next  = state_reg;
      cause_next  = CAUSE_ILLEGAL;
      pc_write_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      retire_c    = 1'b0;
      adr_src     = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALUOP_ADD;
      case (state_reg)
         S_FETCH: begin
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURES;
            ir_write_c = mem_ready;
            pc_write_c = mem_ready;
            if (mem_ready) begin
               state_next = S_DECODE;
            end else if (timer_expired) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_IMM;
            state_next = decode_next(op);
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (mem_ready) begin
               state_next = S_MEMWB;
            end else if (timer_expired) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end
         S_MEMWB: begin
            result_src  = RES_RDATA;
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
            state_next  = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_c = 1'b1;
            if (mem_ready) begin
               retire_c   = 1'b1;
               state_next = S_FETCH;
            end else if (timer_expired) begin
               state_next = S_TRAP;
               cause_next = CAUSE_TIMEOUT;
            end
         end
         S_EXECR: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALUOP_FUNCT;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
            state_next  = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_op     = ALUOP_SUB;
            pc_write_c = zero;
            retire_c   = 1'b1;
            state_next = S_FETCH;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms OldPC+4
            // for the link write in ALUWB.
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write_c = 1'b1;
            state_next = S_ALUWB;
         end
         S_TRAP: begin
            state_next = S_TRAP;
         end
         default: begin
            state_next = S_TRAP;
         end
      endcase
   end

   // Strobes are masked while reset is held so an aborted instruction
   // cannot leak a write into the datapath.
   assign pc_write   = pc_write_c  && rst_n;
   assign ir_write   = ir_write_c  && rst_n;
   assign mem_write  = mem_write_c && rst_n;
   assign reg_write  = reg_write_c && rst_n;
   assign retire     = retire_c    && rst_n;
   assign ret_count  = ret_count_reg;
   assign trap       = trap_reg;
   assign trap_cause = trap_cause_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

   localparam int WL = 16;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [6:0] op = 7'b0;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;
   logic pc_write, adr_src, mem_write, ir_write, reg_write, retire, trap, trap_cause;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [RW-1:0] ret_count;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.WAIT_LIMIT(WL), .RET_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
      .retire(retire), .ret_count(ret_count), .trap(trap), .trap_cause(trap_cause)
   );

   logic [13:0] obs;
   assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                 alu_src_b, alu_op, reg_write, retire};

   int passed = 0;
   int total = 0;
   int exp_ret = 0;

   typedef struct packed {
      logic        ready;
      logic        zflag;
      logic [13:0] v;
   } cyc_t;
   cyc_t q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   // Cycle profile builder: pc, adr, mw, ir, res, a, b, aluop, rw, ret.
   function automatic logic [13:0] mk(input logic pc, input logic adr, input logic mw,
                                       input logic ir, input logic [1:0] res,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic rw,
                                       input logic ret);
      return {pc, adr, mw, ir, res, a, b, aop, rw, ret};
   endfunction

   function automatic logic [13:0] v_fetch(input logic r);
      return mk(r, 1'b0, 1'b0, r, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [13:0] v_memwrite(input logic r);
      return mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, r);
   endfunction
   function automatic logic [13:0] v_beq(input logic z);
      return mk(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1);
   endfunction

   localparam logic [13:0] V_DECODE  = 14'b0_0_0_0_00_01_01_00_0_0;
   localparam logic [13:0] V_MEMADR  = 14'b0_0_0_0_00_10_01_00_0_0;
   localparam logic [13:0] V_MEMREAD = 14'b0_1_0_0_00_00_00_00_0_0;
   localparam logic [13:0] V_MEMWB   = 14'b0_0_0_0_01_00_00_00_1_1;
   localparam logic [13:0] V_EXECR   = 14'b0_0_0_0_00_10_00_10_0_0;
   localparam logic [13:0] V_EXECI   = 14'b0_0_0_0_00_10_01_10_0_0;
   localparam logic [13:0] V_ALUWB   = 14'b0_0_0_0_00_00_00_00_1_1;
   localparam logic [13:0] V_JAL     = 14'b1_0_0_0_00_01_10_00_0_0;
   localparam logic [13:0] V_IDLE    = 14'b0;

   task automatic push(input logic r, input logic z, input logic [13:0] v);
      cyc_t c;
      c.ready = r; c.zflag = z; c.v = v;
      q.push_back(c);
   endtask

   task automatic add_fetch(input int w);
      for (int i = 0; i < w; i++) push(1'b0, 1'b0, v_fetch(1'b0));
      push(1'b1, 1'b0, v_fetch(1'b1));
   endtask

   // Instruction classes: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal.
   function automatic logic [6:0] class_op(input int cls);
      logic [6:0] o;
      case (cls)
         0: o = 7'b0000011;
         1: o = 7'b0100011;
         2: o = 7'b0110011;
         3: o = 7'b0010011;
         4: o = 7'b1100011;
         default: o = 7'b1101111;
      endcase
      return o;
   endfunction

   // Expected cycle-by-cycle profile of one complete instruction.
   task automatic build_instr(input int cls, input int fw, input int mw, input logic z);
      op = class_op(cls);
      add_fetch(fw);
      push(1'b1, 1'b0, V_DECODE);
      case (cls)
         0: begin
            push(1'b1, 1'b0, V_MEMADR);
            for (int i = 0; i < mw; i++) push(1'b0, 1'b0, V_MEMREAD);
            push(1'b1, 1'b0, V_MEMREAD);
            push(1'b1, 1'b0, V_MEMWB);
         end
         1: begin
            push(1'b1, 1'b0, V_MEMADR);
            for (int i = 0; i < mw; i++) push(1'b0, 1'b0, v_memwrite(1'b0));
            push(1'b1, 1'b0, v_memwrite(1'b1));
         end
         2: begin push(1'b1, 1'b0, V_EXECR); push(1'b1, 1'b0, V_ALUWB); end
         3: begin push(1'b1, 1'b0, V_EXECI); push(1'b1, 1'b0, V_ALUWB); end
         4: push(1'b1, z, v_beq(z));
         default: begin push(1'b1, 1'b0, V_JAL); push(1'b1, 1'b0, V_ALUWB); end
      endcase
   endtask

   // Called at a falling edge: drive, sample 1 time unit later, step a cycle.
   task automatic run_queue(input string tag);
      int n = 0;
      while (q.size() > 0) begin
         cyc_t c = q.pop_front();
         mem_ready = c.ready;
         zero = c.zflag;
         #1;
         chk($sformatf("%s cyc%0d", tag, n), {18'b0, obs}, {18'b0, c.v});
         n++;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      chk("rst strobes", {27'b0, pc_write, ir_write, mem_write, reg_write, retire}, 32'd0);
      @(negedge clk);
      chk("rst ret_count", {28'b0, ret_count}, 32'd0);
      chk("rst trap", {30'b0, trap, trap_cause}, 32'd0);
      chk("rst alu_src_b", {30'b0, alu_src_b}, 32'd2);
      rst_n = 1'b1;
      exp_ret = 0;
   endtask

   task automatic end_instr(input string tag);
      exp_ret = (exp_ret + 1) % (1 << RW);
      chk({tag, " ret_count"}, {28'b0, ret_count}, exp_ret);
      chk({tag, " trap"}, {31'b0, trap}, 32'd0);
   endtask

   initial begin
      int cls, fw, mw;
      logic z;
      @(negedge clk);
      do_reset();

      build_instr(2, 0, 0, 1'b0); run_queue("rtype"); end_instr("rtype");
      build_instr(0, 0, 3, 1'b0); run_queue("lw_wait3"); end_instr("lw_wait3");
      build_instr(1, 0, 2, 1'b0); run_queue("sw_wait2"); end_instr("sw_wait2");
      build_instr(4, 0, 0, 1'b1); run_queue("beq_taken"); end_instr("beq_taken");
      build_instr(4, 0, 0, 1'b0); run_queue("beq_not"); end_instr("beq_not");
      build_instr(5, 0, 0, 1'b0); run_queue("jal"); end_instr("jal");
      build_instr(3, 0, 0, 1'b0); run_queue("itype"); end_instr("itype");

      // Randomized program; ret_count wraps in the narrow counter.
      for (int k = 0; k < 40; k++) begin
         cls = int'($urandom_range(0, 5));
         fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WL - 1)) : int'($urandom_range(0, 2));
         mw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WL - 1)) : int'($urandom_range(0, 2));
         z = 1'($urandom_range(0, 1));
         build_instr(cls, fw, mw, z);
         run_queue($sformatf("rnd%0d", k));
         end_instr($sformatf("rnd%0d", k));
      end

      // Reset during the lw write-back cycle: no write, no retire.
      build_instr(0, 0, 0, 1'b0);
      void'(q.pop_back());
      run_queue("lw_abort");
      rst_n = 1'b0;
      #1;
      chk("abort strobes", {27'b0, pc_write, ir_write, mem_write, reg_write, retire}, 32'd0);
      @(negedge clk);
      chk("abort ret_count", {28'b0, ret_count}, 32'd0);
      rst_n = 1'b1;
      exp_ret = 0;

      // Illegal opcode: trap, then 20 more idle cycles.
      op = 7'b1111111;
      add_fetch(0);
      push(1'b1, 1'b0, V_DECODE);
      run_queue("illegal");
      mem_ready = 1'b1;
      #1;
      chk("illegal trap", {30'b0, trap, trap_cause}, 32'd2);
      for (int i = 0; i < 21; i++) push(1'b1, 1'b1, V_IDLE);
      run_queue("trap_idle");
      chk("illegal sticky", {30'b0, trap, trap_cause}, 32'd2);
      do_reset();

      // Fetch timeout after WL stalled cycles.
      for (int i = 0; i < WL; i++) push(1'b0, 1'b0, v_fetch(1'b0));
      run_queue("fetch_to");
      mem_ready = 1'b1;
      #1;
      chk("fetch_to trap", {30'b0, trap, trap_cause}, 32'd3);
      chk("fetch_to idle", {18'b0, obs}, 32'd0);
      @(negedge clk);
      do_reset();

      // Ready on the limit cycle wins.
      op = 7'b0110011;
      add_fetch(WL - 1);
      push(1'b1, 1'b0, V_DECODE);
      run_queue("fetch_edge");
      chk("fetch_edge trap", {31'b0, trap}, 32'd0);
      do_reset();

      // Store timeout holds mem_write through every stalled cycle.
      op = 7'b0100011;
      add_fetch(0);
      push(1'b1, 1'b0, V_DECODE);
      push(1'b1, 1'b0, V_MEMADR);
      for (int i = 0; i < WL; i++) push(1'b0, 1'b0, v_memwrite(1'b0));
      push(1'b1, 1'b0, V_IDLE);
      run_queue("sw_to");
      chk("sw_to trap", {30'b0, trap, trap_cause}, 32'd3);
      chk("sw_to ret_count", {28'b0, ret_count}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
